// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared commands, FSM states and frame field positions
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int FRAME_BITS = 32;
  localparam int CMD_MSB    = 31;
  localparam int CMD_LSB    = 24;
  localparam int ADDR_MSB   = 23;
  localparam int ADDR_LSB   = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_HOLD,
    ST_EXEC
  } state_e;

  function automatic logic [7:0] frame_cmd(input logic [FRAME_BITS-1:0] f);
    return f[CMD_MSB:CMD_LSB];
  endfunction

  function automatic logic [7:0] frame_addr(input logic [FRAME_BITS-1:0] f);
    return f[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic [15:0] frame_data(input logic [FRAME_BITS-1:0] f);
    return f[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - two-flop synchronizer with rise/fall pulses
// The third flop only remembers the previous synchronized level for edge detection.
module spi_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI mode-0 slave fronting a small register memory
// Frames are received, held until an execute strobe, then applied to memory or the tx register.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_n_i,
  input  logic              ss_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic              latch_data_n_i,
  input  logic [IDX_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              frame_valid_o,
  output logic              cmd_error_o
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic latch_sync, latch_rise, latch_fall;

  spi_sync u_sync_ss (
    .clk_i(clock_i), .rst_n_i(reset_n_i), .async_i(ss_n_i),
    .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync u_sync_sclk (
    .clk_i(clock_i), .rst_n_i(reset_n_i), .async_i(sclk_i),
    .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync u_sync_mosi (
    .clk_i(clock_i), .rst_n_i(reset_n_i), .async_i(mosi_i),
    .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_sync u_sync_latch (
    .clk_i(clock_i), .rst_n_i(reset_n_i), .async_i(latch_data_n_i),
    .sync_o(latch_sync), .rise_o(latch_rise), .fall_o(latch_fall)
  );

  logic unused_sync_bits;
  assign unused_sync_bits = ^{sclk_sync, mosi_rise, mosi_fall, latch_sync, latch_rise};

  state_e                  state_q, state_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic                    cmd_error_q, cmd_error_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic [7:0]              rx_cmd;
  logic [ADDR_W-1:0]       rx_addr;
  logic [DATA_W-1:0]       rx_data;
  logic                    addr_ok;
  logic [IDX_W-1:0]        rx_idx;
  logic                    mem_we;

  assign rx_cmd  = frame_cmd(rx_q);
  assign rx_addr = frame_addr(rx_q);
  assign rx_data = frame_data(rx_q);
  assign addr_ok = {1'b0, rx_addr} < DEPTH_LIM;
  assign rx_idx  = rx_addr[IDX_W-1:0];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[rx_idx] <= rx_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cmd_error_d = 1'b0;
    mem_we      = 1'b0;

    // Response shifts out on every sclk fall of any selected frame; a READ EXEC overrides it.
    if (!enable_n_i && !ss_sync && sclk_fall) begin
      tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
    end

    if (enable_n_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            state_d   = ST_RX;
            bit_cnt_d = '0;
            rx_d      = '0;
          end
        end
        ST_RX: begin
          if (ss_rise) begin
            if (bit_cnt_q == 6'(FRAME_BITS)) begin
              state_d = ST_HOLD;
            end else begin
              state_d     = ST_IDLE;
              rx_d        = '0;
              cmd_error_d = 1'b1;
            end
          end else if (sclk_rise) begin
            rx_d = {rx_q[FRAME_BITS-2:0], mosi_sync};
            if (bit_cnt_q != 6'h3f) begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        ST_HOLD: begin
          if (ss_fall) begin
            state_d   = ST_RX;
            bit_cnt_d = '0;
            rx_d      = '0;
          end else if (latch_fall) begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_d = ST_IDLE;
          case (rx_cmd)
            CMD_WRITE: mem_we = addr_ok;
            CMD_READ:  tx_d   = {CMD_READ, rx_addr, addr_ok ? mem_q[rx_idx] : '0};
            default:   cmd_error_d = 1'b1;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign miso_o        = !enable_n_i && !ss_sync && tx_q[FRAME_BITS-1];
  assign frame_valid_o = (state_q == ST_HOLD);
  assign cmd_error_o   = cmd_error_q;
  assign rd_data_o     = mem_q[rd_addr_i];

endmodule
